csr_access_controller: RTL and testbench
========================================

// Module: csr_access_controller
// PURPOSE
// - Sequencer between the core's CSR instruction stage and the shared CSR bus that all configuration registers sit on.
// - Accepts one CSRRW/CSRRS/CSRRC request, performs bus read, computes read-modify-write value, issues bus write, returns old value.
// - Flags accesses no register claims (csrRequestOutput low) as errors; such accesses write nothing.
// PARAMETERS
// - none; widths fixed: address 12 bits, data 32 bits
// PORTS
// clk               in   1   system clock
// rst               in   1   synchronous reset, active-high
// reqValid          in   1   request present; sampled only while reqReady
// reqReady          out  1   controller idle, request accepted this cycle if reqValid
// reqOp             in   2   01=RW 10=RS(set) 11=RC(clear); 00 treated as error
// reqAddress        in   12  CSR address
// reqWriteData      in   32  rs1 value or zero-extended zimm
// reqWriteSuppress  in   1   RS/RC with rs1/zimm==0: no bus write
// respValid         out  1   one-cycle completion pulse
// respReadData      out  32  old CSR value; 0 on error
// respError         out  1   access error, valid with respValid
// csrReadEnable     out  1   CSR bus read strobe
// csrReadAddress    out  12  CSR bus read address
// csrWriteEnable    out  1   CSR bus write strobe
// csrWriteAddress   out  12  CSR bus write address
// csrWriteData      out  32  CSR bus write data
// csrReadData       in   32  OR of all register read outputs
// csrRequestOutput  in   1   OR of all register claim outputs
// BEHAVIOUR
// - Reset: state IDLE; reqReady=1; respValid, respError, csrReadEnable, csrWriteEnable=0; respReadData, csrWriteData, addresses=0.
// - FSM IDLE->READ->WRITE->DONE->IDLE; each state one cycle; no backpressure on response.
// - IDLE: reqReady=1; on reqValid latch op/address/data/suppress, go READ.
// - READ: csrReadEnable=1, csrReadAddress=latched address; register oldValue=csrReadData, hit=csrRequestOutput.
//   hit=0 or op=00 -> error=1, go DONE (WRITE skipped). Otherwise go WRITE.
// - WRITE: newValue RW=data, RS=old|data, RC=old&~data; csrWriteEnable=1 unless suppress (RS/RC only; RW always writes).
// - DONE: respValid=1, respReadData=error?0:oldValue, respError=error; next cycle IDLE with reqReady=1.
// - Latency: accept edge -> respValid 3 cycles later (2 on error); throughput one request per 4 cycles.
// - csrWriteAddress/csrWriteData driven 0 outside WRITE; csrReadAddress 0 outside READ.
// - Read and write strobes never asserted in the same cycle.
// - rst in any state: IDLE next edge; no write committed after rst-sampled edge; pending response dropped.
// - reqValid outside IDLE ignored (not queued).
// CONFIGURATION
// - CSR_READONLY_CHECK_EN defined: address[11:10]==2'b11 with a write (RW, or RS/RC not suppressed) -> respError=1,
//   no bus write, respReadData=0; reads of such addresses (RS/RC suppressed) succeed normally.
// - Undefined: no address-based check; only unclaimed address / op=00 raise error.
// STRUCTURE
// - Shared package: op encodings (CSR_OP_RW/RS/RC), FSM state encodings, read-only address field constant.
// - Sub-module csr_rmw_alu: combinational newValue from op, oldValue, writeData; FSM and bus muxing in top.
// TESTING
// - RW to claimed 0x300 holding 0x0000_00AA, data 0x1234_5678 -> resp old 0xAA, err 0; register then 0x1234_5678.
// - RS 0x300 holding 0x0F, data 0xF0 -> write 0xFF; RC data 0x0F -> write 0xF0; resp old values 0x0F / 0xFF.
// - RS data 0, suppress=1 -> csrWriteEnable never high; resp old value; register unchanged.
// - Unclaimed address 0x7C0 -> respValid 2 cycles after accept, err 1, data 0, no write strobe.
// - With CSR_READONLY_CHECK_EN: RW to 0xC00 -> err 1, no write; RS suppressed to 0xC00 -> err 0 if claimed.
// - rst asserted during WRITE of RW 0xDEAD_BEEF -> no respValid, FSM IDLE, register holds its reset default.

Source files
------------

// File: rtl/csr_access_controller_pkg.sv
// rtl/csr_access_controller_pkg.sv - shared op/state encodings and address helpers for the CSR access controller
package csr_access_controller_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } csr_state_e;

    // Top two address bits equal to this mark a read-only CSR
    localparam logic [1:0] CSR_READONLY_FIELD = 2'b11;

    function automatic logic csr_is_readonly(input logic [CSR_ADDR_W-1:0] addr);
        return addr[CSR_ADDR_W-1:CSR_ADDR_W-2] == CSR_READONLY_FIELD;
    endfunction

    function automatic logic csr_op_writes(input csr_op_e op, input logic suppress);
        return (op == CSR_OP_RW) || ((op != CSR_OP_NONE) && !suppress);
    endfunction

endpackage

// File: rtl/csr_access_controller_rmw_alu.sv
// rtl/csr_access_controller_rmw_alu.sv - combinational read-modify-write value for CSRRW/CSRRS/CSRRC
module csr_rmw_alu
    import csr_access_controller_pkg::*;
(
    input  csr_op_e                 op,
    input  logic [CSR_DATA_W-1:0]   old_value,
    input  logic [CSR_DATA_W-1:0]   write_data,
    output logic [CSR_DATA_W-1:0]   new_value
);

    always_comb begin
        new_value = old_value;
        case (op)
            CSR_OP_RW: new_value = write_data;
            CSR_OP_RS: new_value = old_value | write_data;
            CSR_OP_RC: new_value = old_value & ~write_data;
            default:   new_value = old_value;
        endcase
    end

endmodule

// File: rtl/csr_access_controller.sv
// rtl/csr_access_controller.sv - CSR bus sequencer (read, modify, write, respond); optional CSR_READONLY_CHECK_EN
module csr_access_controller
    import csr_access_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reqValid,
    output logic                    reqReady,
    input  logic [1:0]              reqOp,
    input  logic [CSR_ADDR_W-1:0]   reqAddress,
    input  logic [CSR_DATA_W-1:0]   reqWriteData,
    input  logic                    reqWriteSuppress,
    output logic                    respValid,
    output logic [CSR_DATA_W-1:0]   respReadData,
    output logic                    respError,
    output logic                    csrReadEnable,
    output logic [CSR_ADDR_W-1:0]   csrReadAddress,
    output logic                    csrWriteEnable,
    output logic [CSR_ADDR_W-1:0]   csrWriteAddress,
    output logic [CSR_DATA_W-1:0]   csrWriteData,
    input  logic [CSR_DATA_W-1:0]   csrReadData,
    input  logic                    csrRequestOutput
);

    csr_state_e              state_q, state_d;
    csr_op_e                 op_q, op_d;
    logic [CSR_ADDR_W-1:0]   addr_q, addr_d;
    logic [CSR_DATA_W-1:0]   data_q, data_d;
    logic                    suppress_q, suppress_d;
    logic [CSR_DATA_W-1:0]   old_value_q, old_value_d;

    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [CSR_DATA_W-1:0]   resp_read_data_q, resp_read_data_d;
    logic                    resp_error_q, resp_error_d;
    logic                    csr_read_enable_q, csr_read_enable_d;
    logic [CSR_ADDR_W-1:0]   csr_read_address_q, csr_read_address_d;
    logic                    csr_write_enable_q, csr_write_enable_d;
    logic [CSR_ADDR_W-1:0]   csr_write_address_q, csr_write_address_d;
    logic [CSR_DATA_W-1:0]   csr_write_data_q, csr_write_data_d;

    logic [CSR_DATA_W-1:0]   new_value;
    logic                    will_write;
    logic                    readonly_violation;
    logic                    access_error;

    // The bus read data is combinational during READ, so the new value is
    // formed from it directly and registered straight onto the write bus.
    csr_rmw_alu u_rmw_alu (
        .op         (op_q),
        .old_value  (csrReadData),
        .write_data (data_q),
        .new_value  (new_value)
    );

    always_comb begin
        will_write = csr_op_writes(op_q, suppress_q);
`ifdef CSR_READONLY_CHECK_EN
        readonly_violation = csr_is_readonly(addr_q) && will_write;
`else
        readonly_violation = 1'b0;
`endif
        access_error = !csrRequestOutput || (op_q == CSR_OP_NONE) || readonly_violation;
    end

    always_comb begin
        state_d             = state_q;
        op_d                = op_q;
        addr_d              = addr_q;
        data_d              = data_q;
        suppress_d          = suppress_q;
        old_value_d         = old_value_q;
        req_ready_d         = 1'b0;
        resp_valid_d        = 1'b0;
        resp_read_data_d    = '0;
        resp_error_d        = 1'b0;
        csr_read_enable_d   = 1'b0;
        csr_read_address_d  = '0;
        csr_write_enable_d  = 1'b0;
        csr_write_address_d = '0;
        csr_write_data_d    = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (reqValid) begin
                    state_d            = ST_READ;
                    op_d               = csr_op_e'(reqOp);
                    addr_d             = reqAddress;
                    data_d             = reqWriteData;
                    suppress_d         = reqWriteSuppress;
                    req_ready_d        = 1'b0;
                    csr_read_enable_d  = 1'b1;
                    csr_read_address_d = reqAddress;
                end
            end
            ST_READ: begin
                old_value_d = csrReadData;
                if (access_error) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    state_d             = ST_WRITE;
                    csr_write_enable_d  = will_write;
                    csr_write_address_d = addr_q;
                    csr_write_data_d    = new_value;
                end
            end
            ST_WRITE: begin
                state_d          = ST_DONE;
                resp_valid_d     = 1'b1;
                resp_read_data_d = old_value_q;
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= ST_IDLE;
            op_q                <= CSR_OP_NONE;
            addr_q              <= '0;
            data_q              <= '0;
            suppress_q          <= 1'b0;
            old_value_q         <= '0;
            req_ready_q         <= 1'b1;
            resp_valid_q        <= 1'b0;
            resp_read_data_q    <= '0;
            resp_error_q        <= 1'b0;
            csr_read_enable_q   <= 1'b0;
            csr_read_address_q  <= '0;
            csr_write_enable_q  <= 1'b0;
            csr_write_address_q <= '0;
            csr_write_data_q    <= '0;
        end else begin
            state_q             <= state_d;
            op_q                <= op_d;
            addr_q              <= addr_d;
            data_q              <= data_d;
            suppress_q          <= suppress_d;
            old_value_q         <= old_value_d;
            req_ready_q         <= req_ready_d;
            resp_valid_q        <= resp_valid_d;
            resp_read_data_q    <= resp_read_data_d;
            resp_error_q        <= resp_error_d;
            csr_read_enable_q   <= csr_read_enable_d;
            csr_read_address_q  <= csr_read_address_d;
            csr_write_enable_q  <= csr_write_enable_d;
            csr_write_address_q <= csr_write_address_d;
            csr_write_data_q    <= csr_write_data_d;
        end
    end

    assign reqReady        = req_ready_q;
    assign respValid       = resp_valid_q;
    assign respReadData    = resp_read_data_q;
    assign respError       = resp_error_q;
    assign csrReadEnable   = csr_read_enable_q;
    assign csrReadAddress  = csr_read_address_q;
    assign csrWriteEnable  = csr_write_enable_q;
    assign csrWriteAddress = csr_write_address_q;
    assign csrWriteData    = csr_write_data_q;

endmodule

// File: tb/tb_csr_access_controller.sv
// tb/tb_csr_access_controller.sv - directed vector bench for csr_access_controller with a two-register CSR bus model
module tb_csr_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [1:0]  reqOp;
    logic [11:0] reqAddress;
    logic [31:0] reqWriteData;
    logic        reqWriteSuppress;
    logic        respValid;
    logic [31:0] respReadData;
    logic        respError;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;

    csr_access_controller dut (
        .clk              (clk),
        .rst              (rst),
        .reqValid         (reqValid),
        .reqReady         (reqReady),
        .reqOp            (reqOp),
        .reqAddress       (reqAddress),
        .reqWriteData     (reqWriteData),
        .reqWriteSuppress (reqWriteSuppress),
        .respValid        (respValid),
        .respReadData     (respReadData),
        .respError        (respError),
        .csrReadEnable    (csrReadEnable),
        .csrReadAddress   (csrReadAddress),
        .csrWriteEnable   (csrWriteEnable),
        .csrWriteAddress  (csrWriteAddress),
        .csrWriteData     (csrWriteData),
        .csrReadData      (csrReadData),
        .csrRequestOutput (csrRequestOutput)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] REG300_DEFAULT = 32'h0000_00AA;
    localparam logic [31:0] REGC00_DEFAULT = 32'h0000_0005;

    logic [31:0] reg300;
    logic [31:0] regC00;
    int          wr_total = 0;
    logic [31:0] last_wdata = '0;

    always_comb begin
        csrReadData      = 32'h0;
        csrRequestOutput = 1'b0;
        if (csrReadAddress == 12'h300) csrReadData = reg300;
        if (csrReadAddress == 12'hC00) csrReadData = regC00;
        csrRequestOutput = csrReadEnable && (csrReadAddress == 12'h300 || csrReadAddress == 12'hC00);
    end

    always @(posedge clk) begin
        if (rst) begin
            reg300 <= REG300_DEFAULT;
            regC00 <= REGC00_DEFAULT;
        end else if (csrWriteEnable) begin
            if (csrWriteAddress == 12'h300) reg300 <= csrWriteData;
            if (csrWriteAddress == 12'hC00) regC00 <= csrWriteData;
        end
    end

    always @(negedge clk) begin
        if (csrWriteEnable) begin
            wr_total   = wr_total + 1;
            last_wdata = csrWriteData;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] data;
        logic        sup;
        logic [31:0] exp_old;
        logic        exp_err;
        int          exp_wr;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_bus(input int idx, input int cyc);
        check($sformatf("v%0d_c%0d_strobe_overlap", idx, cyc), {31'b0, csrReadEnable & csrWriteEnable}, 32'h0);
        if (!csrReadEnable)
            check($sformatf("v%0d_c%0d_raddr_idle", idx, cyc), {20'b0, csrReadAddress}, 32'h0);
    endtask

    task automatic do_req(input int idx, input vec_t v);
        int start_wr;
        int lat;
        bit got;
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), {31'b0, reqReady}, 32'h1);
        reqOp            = v.op;
        reqAddress       = v.addr;
        reqWriteData     = v.data;
        reqWriteSuppress = v.sup;
        reqValid         = 1'b1;
        start_wr         = wr_total;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            check_bus(idx, c);
            if (c == 1) begin
                // Request stays asserted with different contents while busy; it must be ignored
                reqOp        = 2'b01;
                reqAddress   = 12'h300;
                reqWriteData = 32'hA5A5_5A5A;
            end
            if (respValid) begin
                got      = 1'b1;
                lat      = c;
                reqValid = 1'b0;
                check($sformatf("v%0d_old", idx), respReadData, v.exp_old);
                check($sformatf("v%0d_err", idx), {31'b0, respError}, {31'b0, v.exp_err});
            end
        end
        reqValid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL v%0d_timeout actual=no_resp required=resp", idx);
        end else begin
            check($sformatf("v%0d_lat", idx), lat, v.exp_lat);
            check($sformatf("v%0d_wr_count", idx), wr_total - start_wr, v.exp_wr);
            if (v.exp_wr != 0) check($sformatf("v%0d_wdata", idx), last_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        //          op     addr     data           sup   old            err   wr  wdata          lat
        vecs[0]  = '{2'b01, 12'h300, 32'h1234_5678, 1'b0, 32'h0000_00AA, 1'b0, 1, 32'h1234_5678, 3};
        vecs[1]  = '{2'b01, 12'h300, 32'h0000_000F, 1'b0, 32'h1234_5678, 1'b0, 1, 32'h0000_000F, 3};
        vecs[2]  = '{2'b10, 12'h300, 32'h0000_00F0, 1'b0, 32'h0000_000F, 1'b0, 1, 32'h0000_00FF, 3};
        vecs[3]  = '{2'b11, 12'h300, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1'b0, 1, 32'h0000_00F0, 3};
        vecs[4]  = '{2'b10, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_00F0, 1'b0, 0, 32'h0,         3};
        vecs[5]  = '{2'b11, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_00F0, 1'b0, 0, 32'h0,         3};
        vecs[6]  = '{2'b01, 12'h7C0, 32'h0000_1234, 1'b0, 32'h0,         1'b1, 0, 32'h0,         2};
        vecs[7]  = '{2'b00, 12'h300, 32'h0000_0055, 1'b0, 32'h0,         1'b1, 0, 32'h0,         2};
        vecs[8]  = '{2'b10, 12'hC00, 32'h0000_0000, 1'b1, 32'h0000_0005, 1'b0, 0, 32'h0,         3};
`ifdef CSR_READONLY_CHECK_EN
        vecs[9]  = '{2'b01, 12'hC00, 32'h0000_0077, 1'b0, 32'h0,         1'b1, 0, 32'h0,         2};
        vecs[10] = '{2'b10, 12'hC00, 32'h0000_0008, 1'b0, 32'h0,         1'b1, 0, 32'h0,         2};
`else
        vecs[9]  = '{2'b01, 12'hC00, 32'h0000_0077, 1'b0, 32'h0000_0005, 1'b0, 1, 32'h0000_0077, 3};
        vecs[10] = '{2'b10, 12'hC00, 32'h0000_0008, 1'b0, 32'h0000_0077, 1'b0, 1, 32'h0000_007F, 3};
`endif
        vecs[11] = '{2'b01, 12'h300, 32'h0000_0001, 1'b1, 32'h0000_00F0, 1'b0, 1, 32'h0000_0001, 3};

        rst              = 1'b1;
        reqValid         = 1'b0;
        reqOp            = 2'b00;
        reqAddress       = '0;
        reqWriteData     = '0;
        reqWriteSuppress = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",      {31'b0, reqReady},       32'h1);
        check("rst_resp_valid", {31'b0, respValid},      32'h0);
        check("rst_resp_err",   {31'b0, respError},      32'h0);
        check("rst_resp_data",  respReadData,            32'h0);
        check("rst_rd_en",      {31'b0, csrReadEnable},  32'h0);
        check("rst_wr_en",      {31'b0, csrWriteEnable}, 32'h0);
        check("rst_raddr",      {20'b0, csrReadAddress}, 32'h0);
        check("rst_waddr",      {20'b0, csrWriteAddress},32'h0);
        check("rst_wdata",      csrWriteData,            32'h0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_req(i, vecs[i]);
            if (i == 0) check("v0_reg300", reg300, 32'h1234_5678);
        end
        check("reg300_final", reg300, 32'h0000_0001);

        // Reset landing on the WRITE cycle of an RW must abort the access
        @(negedge clk);
        reqOp            = 2'b01;
        reqAddress       = 12'h300;
        reqWriteData     = 32'hDEAD_BEEF;
        reqWriteSuppress = 1'b0;
        reqValid         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("rst_seq_read", {31'b0, csrReadEnable}, 32'h1);
        @(negedge clk);
        check("rst_seq_wr_en", {31'b0, csrWriteEnable}, 32'h1);
        check("rst_seq_wdata", csrWriteData, 32'hDEAD_BEEF);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_seq_ready",  {31'b0, reqReady},  32'h1);
        check("rst_seq_wr_off", {31'b0, csrWriteEnable}, 32'h0);
        check("rst_seq_reg",    reg300, REG300_DEFAULT);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (respValid) seen++;
            end
            check("rst_seq_no_resp", seen, 0);
        end
        do_req(12, '{2'b10, 12'h300, 32'h0, 1'b1, REG300_DEFAULT, 1'b0, 0, 32'h0, 3});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
